// File: rtl/match_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : match_event_logger
// Brief    : Records runs of the detector match flag as {start_ts, length}
//            entries in a first-word-fall-through FIFO with event/drop totals.
// Revision : 1.0
// ============================================================================
module match_event_logger #(
  parameter int TS_W  = 16,
  parameter int LEN_W = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     z,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [TS_W-1:0]          out_ts,
  output logic [LEN_W-1:0]         out_len,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         event_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     busy
);
  localparam int               c_AW         = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_FULL_LEVEL = (c_AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_z_q;
  logic [TS_W-1:0]          r_ts;
  logic [TS_W-1:0]          r_start_ts;
  logic [LEN_W-1:0]         r_run_len;
  logic [CNT_W-1:0]         r_event_count;
  logic [CNT_W-1:0]         r_drop_count;
  logic [TS_W+LEN_W-1:0]    r_mem [DEPTH];
  logic [c_AW:0]            r_wr_ptr;
  logic [c_AW:0]            r_rd_ptr;

  logic                     w_rise;
  logic                     w_cont;
  logic                     w_fall;
  logic [c_AW:0]            w_level;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_wr_en;
  logic                     w_drop;
  logic [TS_W+LEN_W-1:0]    w_head;

  always_comb begin
    w_rise      = z & ~r_z_q;
    w_cont      = z & r_z_q;
    w_fall      = ~z & r_z_q;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_rise) w_state_nxt = S_RUN;
      S_RUN:   if (w_fall) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    w_level   = r_wr_ptr - r_rd_ptr;
    w_full    = (w_level == c_FULL_LEVEL);
    w_pop     = (w_level != '0) & out_ready;
    w_wr_en   = w_fall & (~w_full | w_pop);
    w_drop    = w_fall & w_full & ~w_pop;
    w_head    = r_mem[r_rd_ptr[c_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_z_q         <= 1'b0;
      r_ts          <= '0;
      r_start_ts    <= '0;
      r_run_len     <= '0;
      r_event_count <= '0;
      r_drop_count  <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_z_q   <= z;
      r_ts    <= r_ts + 1'b1;
      if (w_rise) begin
        r_start_ts <= r_ts;
        r_run_len  <= LEN_W'(1);
      end else if (w_cont && r_run_len != '1) begin
        r_run_len <= r_run_len + 1'b1;
      end
      if (w_fall && r_event_count != '1)
        r_event_count <= r_event_count + 1'b1;
      if (w_drop && r_drop_count != '1)
        r_drop_count <= r_drop_count + 1'b1;
      if (w_wr_en)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr_en)
      r_mem[r_wr_ptr[c_AW-1:0]] <= {r_start_ts, r_run_len};
  end

  always_comb begin
    out_valid   = (w_level != '0);
    out_ts      = out_valid ? w_head[TS_W+LEN_W-1:LEN_W] : '0;
    out_len     = out_valid ? w_head[LEN_W-1:0] : '0;
    fifo_level  = w_level;
    event_count = r_event_count;
    drop_count  = r_drop_count;
    busy        = (r_state == S_RUN);
  end
endmodule
`default_nettype wire

// File: tb/tb_match_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_match_event_logger
// Brief    : Directed and random checks of match_event_logger against a
//            run/queue reference model.
// Revision : 1.0
// ============================================================================
module tb_match_event_logger;
  localparam int TS_W  = 16;
  localparam int LEN_W = 8;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1, z = 1'b0, out_ready = 1'b0;
  logic             out_valid, busy;
  logic [TS_W-1:0]  out_ts;
  logic [LEN_W-1:0] out_len;
  logic [LW-1:0]    fifo_level;
  logic [CNT_W-1:0] event_count, drop_count;

  match_event_logger #(.TS_W(TS_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .z(z), .out_ready(out_ready),
    .out_valid(out_valid), .out_ts(out_ts), .out_len(out_len),
    .fifo_level(fifo_level), .event_count(event_count),
    .drop_count(drop_count), .busy(busy));

  // Narrow-timestamp instance for the wrap scenario
  logic             reset2 = 1'b1, z2 = 1'b0, rdy2 = 1'b0;
  logic             valid2, busy2;
  logic [3:0]       ts2;
  logic [LEN_W-1:0] len2;
  logic [LW-1:0]    level2;
  logic [CNT_W-1:0] ev2, drop2;

  match_event_logger #(.TS_W(4), .LEN_W(LEN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut2 (
    .clk(clk), .reset(reset2), .z(z2), .out_ready(rdy2),
    .out_valid(valid2), .out_ts(ts2), .out_len(len2),
    .fifo_level(level2), .event_count(ev2),
    .drop_count(drop2), .busy(busy2));

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct { int ts; int len; } ent_t;
  ent_t q[$];
  int   m_ts, m_start, m_n, m_ev, m_drop;
  bit   m_prev_z, m_in_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: a run is a list of consecutive high samples; on its end the
  // entry {first sample time, min(count, 255)} joins the queue if room exists.
  task automatic model_edge(input bit zv, input bit rdy, input bit rst);
    bit pop;
    if (rst) begin
      m_ts = 0; m_start = 0; m_n = 0; m_ev = 0; m_drop = 0;
      m_prev_z = 0; m_in_run = 0; q.delete();
      return;
    end
    pop = rdy && (q.size() > 0);
    if (pop) void'(q.pop_front());
    if (zv) begin
      if (!m_prev_z) begin m_start = m_ts; m_n = 0; m_in_run = 1; end
      m_n++;
    end else if (m_prev_z) begin
      ent_t e;
      e.ts  = m_start;
      e.len = (m_n > 255) ? 255 : m_n;
      m_ev  = (m_ev < 65535) ? m_ev + 1 : m_ev;
      if (q.size() < DEPTH) q.push_back(e);
      else m_drop = (m_drop < 65535) ? m_drop + 1 : m_drop;
      m_in_run = 0;
    end
    m_prev_z = zv;
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic check_all();
    check("valid", 32'(out_valid), 32'(q.size() > 0));
    check("level", 32'(fifo_level), 32'(q.size()));
    check("event_count", 32'(event_count), 32'(m_ev));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    check("busy", 32'(busy), 32'(m_in_run));
    if (q.size() > 0) begin
      check("head_ts", 32'(out_ts), 32'(q[0].ts));
      check("head_len", 32'(out_len), 32'(q[0].len));
    end
  endtask

  task automatic step(input bit zv, input bit rdy, input bit rst);
    @(negedge clk);
    z = zv; out_ready = rdy; reset = rst;
    @(posedge clk);
    model_edge(zv, rdy, rst);
    #1;
    check_all();
  endtask

  task automatic step2(input bit zv, input bit rdy, input bit rst);
    @(negedge clk);
    z2 = zv; rdy2 = rdy; reset2 = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    step(0, 0, 1);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ts", 32'(out_ts), 0);
    check("rst_len", 32'(out_len), 0);

    // Single run at ts 5,6,7
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check("single_busy_in_run", 32'(busy), 1);
    step(0, 0, 0);
    check("single_ts", 32'(out_ts), 5);
    check("single_len", 32'(out_len), 3);
    check("single_ev", 32'(event_count), 1);
    check("single_level", 32'(fifo_level), 1);
    check("single_busy", 32'(busy), 0);

    // Length saturation from ts 10
    step(0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 0, 0);
    step(0, 0, 0);
    check("sat_ts", 32'(out_ts), 10);
    check("sat_len", 32'(out_len), 255);

    // Overflow: pulses at ts 1,3,...,19
    step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) begin step(1, 0, 0); step(0, 0, 0); end
    check("ovf_level", 32'(fifo_level), 8);
    check("ovf_ev", 32'(event_count), 10);
    check("ovf_drop", 32'(drop_count), 2);
    check("ovf_head_ts", 32'(out_ts), 1);
    check("ovf_head_len", 32'(out_len), 1);
    for (int i = 0; i < 8; i++) begin
      check("drain_ts", 32'(out_ts), 32'(2 * i + 1));
      step(0, 1, 0);
    end
    check("drain_empty", 32'(out_valid), 0);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) begin step(1, 0, 0); step(0, 0, 0); end
    check("full_level", 32'(fifo_level), 8);
    step(1, 0, 0);
    step(0, 1, 0);
    check("pp_level", 32'(fifo_level), 8);
    check("pp_drop", 32'(drop_count), 2);
    check("pp_ev", 32'(event_count), 19);

    // Reset in the middle of a run with z held high
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    check("rmr_ev", 32'(event_count), 1);
    check("rmr_level", 32'(fifo_level), 1);
    check("rmr_ts", 32'(out_ts), 0);
    check("rmr_len", 32'(out_len), 2);

    // Random runs, reader stalls and occasional resets
    step(0, 0, 1);
    begin
      bit zr = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 2) == 0) zr = ~zr;
        step(zr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 499) == 0));
      end
    end

    // Timestamp wrap on the 4-bit instance
    reset = 1'b1;
    step2(0, 0, 1);
    for (int i = 0; i < 15; i++) step2(0, 0, 0);
    for (int i = 0; i < 3; i++) step2(1, 0, 0);
    step2(0, 0, 0);
    check("wrap_ts", 32'(ts2), 15);
    check("wrap_len", 32'(len2), 3);
    step2(0, 0, 0);
    step2(1, 1, 0);
    step2(0, 0, 0);
    check("wrap2_level", 32'(level2), 1);
    check("wrap2_ts", 32'(ts2), 4);
    check("wrap2_len", 32'(len2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/match_event_logger.md
# match_event_logger

Consumes the single-bit match flag `z` from the multi-stream sequence detector and records each match run as a timestamped FIFO entry. A run is a maximal span of consecutive clock edges at which `z` is sampled high. Each entry holds the run's start timestamp and its length in cycles. A downstream reader drains entries over a valid/ready interface, and the block keeps running totals of completed runs and of runs dropped on overflow.

## Interface
- `TS_W`, 16: free-running timestamp width.
- `LEN_W`, 8: run-length field width; saturates.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CNT_W`, 16: event and drop counter width; saturate.

- `clk`  in  1: single clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-high; clears all state at the next posedge.
- `z`  in  1: match flag from the detector. Upstream drives it on negedge, so it is stable at posedge.
- `out_ready`  in  1: reader accepts the head entry.
- `out_valid`  out  1: FIFO non-empty.
- `out_ts`  out  TS_W: head entry start timestamp.
- `out_len`  out  LEN_W: head entry run length.
- `fifo_level`  out  $clog2(DEPTH)+1: entries held.
- `event_count`  out  CNT_W: completed runs, including dropped ones.
- `drop_count`  out  CNT_W: runs lost to a full FIFO.
- `busy`  out  1: a run is in progress.

## Operation
- Reset values: `out_valid`=0, `fifo_level`=0, `event_count`=0, `drop_count`=0, `busy`=0, `out_ts`=0, `out_len`=0.
- Internal reset values: `ts`=0, `z_q`=0, `run_len`=0, `start_ts`=0, FIFO pointers=0.
- `ts` increments by 1 at every non-reset posedge and wraps modulo 2^TS_W.
- `z_q` holds `z` from the previous posedge.
- Run FSM has two states: IDLE (`busy`=0) and RUN (`busy`=1). At each posedge, based on `z` and `z_q`:
  - `z`=1, `z_q`=0 (rise): `start_ts` takes the pre-edge `ts`, `run_len`=1, go to RUN.
  - `z`=1, `z_q`=1: `run_len` increments and saturates at 2^LEN_W-1.
  - `z`=0, `z_q`=1 (fall): push {`start_ts`, `run_len`}, `event_count` increments (saturating), go to IDLE.
  - `z`=0, `z_q`=0: no action.
- A run of N sampled-high edges produces `out_len`=min(N, 2^LEN_W-1).
- Push when full with no pop in the same cycle: the entry is discarded, `drop_count` increments (saturating), and FIFO contents are unchanged.
- Pop occurs when `out_valid` and `out_ready` are both high at a posedge.
- Push and pop in the same cycle are always both accepted, including when full. `fifo_level` is then unchanged.
- A push into an empty FIFO cannot coincide with a pop, because `out_valid` was 0.
- FIFO is first-word-fall-through: `out_ts`/`out_len` always show the head entry and are don't-care while `out_valid`=0.
- Reset during a run abandons it: no entry is pushed and counters clear. Because `z_q` clears, a `z` that stays high produces a rise at the first posedge after reset, with `start_ts`=0.

## Timing
- Entry latency: `out_valid`, `out_ts` and `out_len` update at the same posedge that samples the fall. Entries become visible 1 edge after the last high sample.
- `busy` rises at the rise edge and falls at the fall edge.
- `event_count`, `drop_count` and `fifo_level` update at the same edge as the push/pop they reflect.
- A pop at edge k presents the next entry, or deasserts `out_valid`, immediately after edge k.
- Back-to-back runs are supported: a sequence 1,0,1 yields two entries of length 1, with start timestamps 2 apart.
- Throughput: at most one push and one pop per cycle.

## Test plan
- **Single run:** reset, `out_ready`=0, `z`=1 at edges where `ts`=5,6,7, `z`=0 after that. Expect one entry {ts 5, len 3} visible after the fall edge, `event_count`=1, `fifo_level`=1, `busy` low.
- **Length saturation:** `z` high for 300 edges starting at `ts`=10. Expect `out_len`=255 and `out_ts`=10.
- **Overflow:** `out_ready`=0, ten single-edge pulses at `ts`=1,3,…,19. Expect `fifo_level`=8, `event_count`=10, `drop_count`=2, and head {ts 1, len 1}. Draining yields `ts` 1..15 in order, then `out_valid`=0.
- **Push+pop at full:** FIFO full, `out_ready`=1 on the same edge as a fall. Expect the entry accepted, `fifo_level` stays 8, `drop_count` unchanged.
- **Reset mid-run:** `z` high for 4 edges, `reset` for 1 edge with `z` still high, then `z` high for 2 more edges and low. Expect exactly one entry {ts 0, len 2} and `event_count`=1.
- **Timestamp wrap:** with TS_W=4, a run starting at `ts`=15 of length 3 gives `out_ts`=15, `out_len`=3. A run starting 2 edges after its fall gives `out_ts`=4.
